// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one strobe-protocol fpu_multiplier between NUM_REQ requesters.
// Optional watchdog enabled by defining FPU_ARB_TIMEOUT_EN; the port list is the same either way.
module fpu_mul_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int STB_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            mul_a,
  output logic [31:0]            mul_b,
  output logic                   mul_a_stb,
  output logic                   mul_b_stb,
  input  logic [31:0]            mul_z,
  input  logic                   mul_z_stb,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_z,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int SC_W = (STB_CYCLES > 1) ? $clog2(STB_CYCLES + 1) : 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Handshake: req_valid[i] is held until req_ready[i]; req_ready is a one-cycle,
  // one-hot pulse in IDLE and the operands are captured at that same clock edge.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;
  logic [SC_W-1:0]   stb_cnt_q, stb_cnt_d;
  logic [31:0]       z_q, z_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   cand;
  logic [NUM_REQ-1:0] gnt_vec;
  logic              grant;
  logic              in_op;
  logic              take_z;
  logic              take_tmo;
  logic              tmo_hit;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign grant    = (state_q == IDLE) && gnt_found;
  assign in_op    = (state_q == ISSUE) || (state_q == WAIT);
  assign take_z   = in_op && mul_z_stb;
  assign take_tmo = in_op && !mul_z_stb && tmo_hit;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gid_d     = gid_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    stb_cnt_d = stb_cnt_q;
    z_d       = z_q;
    id_d      = id_q;
    gnt_vec   = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          gnt_vec[gnt_idx] = 1'b1;
          op_a_d    = req_a[32*gnt_idx +: 32];
          op_b_d    = req_b[32*gnt_idx +: 32];
          gid_d     = gnt_idx;
          rr_d      = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          stb_cnt_d = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (take_z || take_tmo) begin
          state_d = RESP;
        end else if (stb_cnt_q == SC_W'(STB_CYCLES - 1)) begin
          state_d = WAIT;
        end else begin
          stb_cnt_d = stb_cnt_q + SC_W'(1);
        end
      end
      WAIT: begin
        if (take_z || take_tmo) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A genuine product beats a coincident timeout.
    if (take_z || take_tmo) begin
      id_d = gid_q;
      z_d  = take_z ? mul_z : QNAN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      gid_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      stb_cnt_q <= '0;
      z_q       <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gid_q     <= gid_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      stb_cnt_q <= stb_cnt_d;
      z_q       <= z_d;
      id_q      <= id_d;
    end
  end

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // Counts every ISSUE/WAIT cycle since the grant edge.
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q;
    if (grant)      tmo_d = '0;
    else if (in_op) tmo_d = tmo_q + TMO_W'(1);
    if (take_z)        err_d = 1'b0;
    else if (take_tmo) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q && (state_q == RESP);
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Grants are suppressed while reset is held even though state already reads IDLE.
  assign req_ready = rst ? '0 : gnt_vec;
  assign mul_a     = op_a_q;
  assign mul_b     = op_b_q;
  assign mul_a_stb = (state_q == ISSUE);
  assign mul_b_stb = (state_q == ISSUE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_z     = z_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Bench for fpu_mul_arbiter: behavioural multiplier stub with programmable latency,
// directed requests, and a response scoreboard fed by an expected queue.
module tb_fpu_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int EW      = 47;  // {lat[7:0], stb[3:0], err, id[1:0], z[31:0]}

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = 4'hF;
  logic [32*NUM_REQ-1:0] req_a = '0;
  logic [32*NUM_REQ-1:0] req_b = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           mul_a, mul_b, mul_z;
  logic                  mul_a_stb, mul_b_stb, mul_z_stb;
  logic                  rsp_valid, rsp_err, busy;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_z;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [EW-1:0] exp_q[$];

  fpu_mul_arbiter #(.NUM_REQ(NUM_REQ), .STB_CYCLES(3), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb),
    .mul_b_stb(mul_b_stb), .mul_z(mul_z), .mul_z_stb(mul_z_stb), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_err(rsp_err), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- multiplier stub ----------------
  int          stub_lat = 4;  // 0 = never answer
  int          stub_cnt;
  logic        stub_busy, stub_stb_q, stb_prev, spur;
  logic [31:0] stub_z;

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40000000_40400000: return 32'h40C00000;  // 2*3
      64'h3F800000_3F800000: return 32'h3F800000;  // 1*1
      64'hC0000000_40800000: return 32'hC1000000;  // -2*4
      64'h3F000000_3F000000: return 32'h3E800000;  // .5*.5
      64'h40800000_3F000000: return 32'h40000000;  // 4*.5
      64'h40400000_40400000: return 32'h41100000;  // 3*3
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  initial spur = 1'b0;
  assign mul_z_stb = stub_stb_q | spur;
  assign mul_z     = stub_z;

  always @(posedge clk) begin
    stb_prev <= mul_a_stb;
    if (rst) begin
      stub_stb_q <= 1'b0;
      stub_busy  <= 1'b0;
      stub_cnt   <= 0;
      stub_z     <= 32'h0;
    end else begin
      stub_stb_q <= 1'b0;
      if (mul_a_stb && !stb_prev) begin
        stub_busy <= 1'b1;
        stub_cnt  <= 1;
        stub_z    <= ref_mul(mul_a, mul_b);
      end else if (stub_busy) begin
        if (stub_lat != 0 && stub_cnt == stub_lat) begin
          stub_stb_q <= 1'b1;
          stub_busy  <= 1'b0;
        end else begin
          stub_cnt <= stub_cnt + 1;
        end
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] z, input logic err, input int lat);
    logic [7:0] l;
    logic [1:0] i;
    l = 8'(lat);
    i = 2'(id);
    exp_q.push_back({l, 4'd3, err, i, z});
  endtask

  // ---------------- monitor ----------------
  int gnt_cyc = 0;
  int stb_a_seen = 0;
  int stb_b_seen = 0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      stb_a_seen = 0;
      stb_b_seen = 0;
    end else begin
      if (|req_ready) begin
        gnt_cyc    = cyc;
        stb_a_seen = 0;
        stb_b_seen = 0;
      end
      if (mul_a_stb) stb_a_seen++;
      if (mul_b_stb) stb_b_seen++;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {31'h0, rsp_err, rsp_id, rsp_z}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(e[33:32]));
          check("rsp_z", 64'(rsp_z), 64'(e[31:0]));
          check("rsp_err", 64'(rsp_err), 64'(e[34]));
          check("stb_a_cycles", 64'(stb_a_seen), 64'(e[38:35]));
          check("stb_b_cycles", 64'(stb_b_seen), 64'(e[38:35]));
          check("latency", 64'(cyc - gnt_cyc), 64'(e[46:39]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'h0);
  endtask

  task automatic run(input logic [NUM_REQ-1:0] mask);
    logic [NUM_REQ-1:0] pending, g;
    int n;
    @(posedge clk);
    #1;
    req_valid = req_valid | mask;
    pending   = mask;
    n = 0;
    while (pending != 0 && n < 500) begin
      @(negedge clk);
      g = req_ready;
      if (g != 0) check("grant_onehot", 64'($countones(g) == 1 && (g & ~pending) == 0), 64'h1);
      @(posedge clk);
      #1;
      req_valid = req_valid & ~g;
      pending   = pending & ~g;
      n++;
    end
    if (pending != 0) check("grant_timeout", 64'(pending), 64'h0);
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held with all requesters asserting.
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs",
            {req_ready, busy, mul_a_stb, mul_b_stb, rsp_valid, rsp_err, rsp_id, 8'h0, 40'h0},
            64'h0);
      check("reset_data", {mul_a, mul_b | rsp_z}, 64'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '0;

    // Single request from requester 1, pointer 0 -> 2.
    stub_lat = 4;
    set_op(1, 32'h40000000, 32'h40400000);
    push_exp(1, 32'h40C00000, 1'b0, 7);
    run(4'b0010);

    // Product returned in the last ISSUE cycle: minimum latency; pointer -> 3.
    stub_lat = 1;
    set_op(2, 32'h40800000, 32'h3F000000);
    push_exp(2, 32'h40000000, 1'b0, 4);
    run(4'b0100);

    // Requesters 0 and 2 together with pointer at 3 -> 0 then 2.
    stub_lat = 4;
    set_op(0, 32'h3F800000, 32'h3F800000);
    set_op(2, 32'hC0000000, 32'h40800000);
    push_exp(0, 32'h3F800000, 1'b0, 7);
    push_exp(2, 32'hC1000000, 1'b0, 7);
    run(4'b0101);

    // All four request with pointer at 3 -> 3, 0, 1, 2.
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'h3F000000, 32'h3F000000);
    push_exp(3, 32'h3E800000, 1'b0, 7);
    push_exp(0, 32'h3E800000, 1'b0, 7);
    push_exp(1, 32'h3E800000, 1'b0, 7);
    push_exp(2, 32'h3E800000, 1'b0, 7);
    run(4'b1111);

    // Stray product strobe while idle must not produce a response.
    @(posedge clk);
    #1;
    spur = 1'b1;
    @(posedge clk);
    #1;
    spur = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_spur", {62'h0, busy, rsp_valid}, 64'h0);

`ifdef FPU_ARB_TIMEOUT_EN
    // Multiplier never answers: watchdog response, then normal service resumes.
    stub_lat = 0;
    set_op(0, 32'h3F800000, 32'h40000000);
    push_exp(0, 32'h7FC00000, 1'b1, 65);
    run(4'b0001);
    stub_lat = 4;
    set_op(0, 32'h3F800000, 32'h3F800000);
    push_exp(0, 32'h3F800000, 1'b0, 7);
    run(4'b0001);
`endif

    // Reset during WAIT aborts the operation silently.
    stub_lat = 20;
    set_op(1, 32'h40400000, 32'h40400000);
    @(posedge clk);
    #1;
    req_valid = 4'b0010;
    @(negedge clk);
    check("abort_grant", 64'(req_ready), 64'h2);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("abort_in_wait", {61'h0, busy, mul_a_stb, rsp_valid}, 64'h4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", {59'h0, busy, mul_a_stb, mul_b_stb, rsp_valid, |req_ready}, 64'h0);
    repeat (25) @(negedge clk);
    check("abort_quiet", {62'h0, busy, rsp_valid}, 64'h0);
    stub_lat = 4;
    push_exp(1, 32'h41100000, 1'b0, 7);
    run(4'b0010);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
